instruction_prefetch: RTL and testbench

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

---
 rtl/instruction_prefetch_pkg.sv | 34 +++
 rtl/instruction_prefetch_queue.sv | 76 +++++++
 rtl/instruction_prefetch.sv | 104 ++++++++++
 tb/tb_instruction_prefetch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_prefetch_pkg.sv
// Shared types for the instruction prefetch unit: FSM states and redirect selection.
package instruction_prefetch_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } pf_state_e;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_INT  = 2'd1,
      SEL_BR   = 2'd2,
      SEL_PRED = 2'd3
   } redir_sel_e;

   localparam int unsigned INSTR_BYTES = 4;

   // Interrupt always wins; branch and prediction are masked while an interrupt is pending.
   function automatic redir_sel_e select_redirect(input logic int_req, input logic br_req,
                                                  input logic pred_req, input logic int_pending);
      redir_sel_e sel;
      sel = SEL_NONE;
      if (int_req) begin
         sel = SEL_INT;
      end else if (!int_pending && br_req) begin
         sel = SEL_BR;
      end else if (!int_pending && pred_req) begin
         sel = SEL_PRED;
      end
      return sel;
   endfunction

endpackage

// File: rtl/instruction_prefetch_queue.sv
// Prefetch FIFO holding {pc, instr} pairs; head outputs are registered and hold when empty.
module prefetch_queue #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned ILEN  = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     flush_in,
   input  logic                     push_in,
   input  logic [XLEN-1:0]          push_pc_in,
   input  logic [ILEN-1:0]          push_instr_in,
   input  logic                     pop_in,
   output logic [$clog2(DEPTH):0]   count_out,
   output logic                     valid_out,
   output logic [XLEN-1:0]          pc_out,
   output logic [ILEN-1:0]          instr_out
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = XLEN + ILEN;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
   logic [CW-1:0] count_d;
   logic [EW-1:0] head_d;
   logic          pop_eff;

   // Next pointers/count, and the entry that will sit at the head after this edge.
   always_comb begin
      pop_eff  = pop_in && (count_out != '0);
      rd_ptr_d = rd_ptr_q + AW'(pop_eff);
      wr_ptr_d = wr_ptr_q + AW'(push_in);
      count_d  = count_out + CW'(push_in) - CW'(pop_eff);
      if (flush_in) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
      // A push landing exactly at the new head slot is forwarded straight to the outputs.
      if (push_in && (wr_ptr_q == rd_ptr_d)) begin
         head_d = {push_pc_in, push_instr_in};
      end else begin
         head_d = mem[rd_ptr_d];
      end
   end

   // Pointer, occupancy and head-output registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_out <= '0;
         valid_out <= 1'b0;
         pc_out    <= '0;
         instr_out <= '0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_out <= count_d;
         valid_out <= (count_d != '0);
         if (count_d != '0) begin
            {pc_out, instr_out} <= head_d;
         end
      end
   end

   // Storage write; contents need no reset since only written slots are ever read.
   always_ff @(posedge clk_in) begin
      if (push_in && !flush_in) begin
         mem[wr_ptr_q] <= {push_pc_in, push_instr_in};
      end
   end

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetch: issues word fetches, filters stale responses by epoch, queues for decode.
module instruction_prefetch
   import instruction_prefetch_pkg::*;
#(
   parameter int unsigned     XLEN     = 64,
   parameter int unsigned     ILEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   int_redirect_in,
   input  logic [XLEN-1:0]        int_pc_in,
   input  logic                   br_redirect_in,
   input  logic [XLEN-1:0]        br_pc_in,
   input  logic                   pred_redirect_in,
   input  logic [XLEN-1:0]        pred_pc_in,
   input  logic                   int_pending_in,
   output logic                   imem_req_out,
   output logic [XLEN-1:0]        imem_addr_out,
   input  logic [ILEN-1:0]        imem_rdata_in,
   output logic                   instr_valid_out,
   input  logic                   instr_ready_in,
   output logic [XLEN-1:0]        pc_out,
   output logic [ILEN-1:0]        instr_out,
   output logic [$clog2(DEPTH):0] count_out
);

   localparam int unsigned CW  = $clog2(DEPTH) + 1;
   localparam int unsigned CW1 = CW + 1;

   pf_state_e       state_q, state_d;
   redir_sel_e      sel;
   logic [XLEN-1:0] fetch_pc_q, target, req_pc_q;
   logic            epoch_q, epoch_d, req_epoch_q, inflight_q;
   logic            redirect, credit, push, pop;

   // Redirect arbitration, credit check, request issue and queue control.
   always_comb begin
      sel      = SEL_NONE;
      target   = fetch_pc_q;
      state_d  = state_q;
      if (state_q != ST_BOOT) begin
         sel = select_redirect(int_redirect_in, br_redirect_in, pred_redirect_in, int_pending_in);
      end
      unique case (sel)
         SEL_INT:  target = int_pc_in;
         SEL_BR:   target = br_pc_in;
         SEL_PRED: target = pred_pc_in;
         default:  target = fetch_pc_q;
      endcase
      redirect      = (sel != SEL_NONE);
      credit        = (CW1'(count_out) + CW1'(inflight_q)) < CW1'(DEPTH);
      imem_req_out  = (state_q != ST_BOOT) && (redirect || credit);
      imem_addr_out = target & ~XLEN'(3);
      pop           = instr_valid_out && instr_ready_in;
      push          = inflight_q && !redirect && (req_epoch_q == epoch_q);
      epoch_d       = epoch_q ^ redirect;
      unique case (state_q)
         ST_BOOT: state_d = ST_RUN;
         default: state_d = redirect ? ST_FLUSH : ST_RUN;
      endcase
   end

   // FSM state, fetch PC and in-flight request tracking.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= ST_BOOT;
         fetch_pc_q  <= RESET_PC;
         epoch_q     <= 1'b0;
         req_epoch_q <= 1'b0;
         inflight_q  <= 1'b0;
         req_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         epoch_q    <= epoch_d;
         inflight_q <= imem_req_out;
         if (imem_req_out) begin
            fetch_pc_q  <= imem_addr_out + XLEN'(INSTR_BYTES);
            req_pc_q    <= imem_addr_out;
            req_epoch_q <= epoch_d;
         end
      end
   end

   prefetch_queue #(
      .XLEN  (XLEN),
      .ILEN  (ILEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .flush_in      (redirect),
      .push_in       (push),
      .push_pc_in    (req_pc_q),
      .push_instr_in (imem_rdata_in),
      .pop_in        (pop),
      .count_out     (count_out),
      .valid_out     (instr_valid_out),
      .pc_out        (pc_out),
      .instr_out     (instr_out)
   );

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch; memory returns addr>>2 one cycle after each request.
module tb_instruction_prefetch;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        int_redirect_in, br_redirect_in, pred_redirect_in, int_pending_in;
   logic [63:0] int_pc_in, br_pc_in, pred_pc_in;
   logic        imem_req_out;
   logic [63:0] imem_addr_out;
   logic [31:0] imem_rdata_in;
   logic        instr_valid_out;
   logic        instr_ready_in;
   logic [63:0] pc_out;
   logic [31:0] instr_out;
   logic [2:0]  count_out;

   int checks   = 0;
   int failures = 0;

   instruction_prefetch dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .int_redirect_in  (int_redirect_in),
      .int_pc_in        (int_pc_in),
      .br_redirect_in   (br_redirect_in),
      .br_pc_in         (br_pc_in),
      .pred_redirect_in (pred_redirect_in),
      .pred_pc_in       (pred_pc_in),
      .int_pending_in   (int_pending_in),
      .imem_req_out     (imem_req_out),
      .imem_addr_out    (imem_addr_out),
      .imem_rdata_in    (imem_rdata_in),
      .instr_valid_out  (instr_valid_out),
      .instr_ready_in   (instr_ready_in),
      .pc_out           (pc_out),
      .instr_out        (instr_out),
      .count_out        (count_out)
   );

   always #5 clk_in = ~clk_in;

   // Memory model: word index of the requested address, valid the following cycle.
   always @(posedge clk_in) begin
      if (imem_req_out) imem_rdata_in <= 32'(imem_addr_out >> 2);
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #2;
   endtask

   initial begin
      int n;
      rst_n_in = 1'b0;
      int_redirect_in = 1'b0; br_redirect_in = 1'b0; pred_redirect_in = 1'b0;
      int_pending_in = 1'b0;
      int_pc_in = '0; br_pc_in = '0; pred_pc_in = '0;
      imem_rdata_in = '0;
      instr_ready_in = 1'b1;

      // Reset values
      repeat (2) @(posedge clk_in);
      #2;
      chk("rst_req",   64'(imem_req_out), 64'd0);
      chk("rst_addr",  imem_addr_out, 64'd0);
      chk("rst_valid", 64'(instr_valid_out), 64'd0);
      chk("rst_count", 64'(count_out), 64'd0);
      chk("rst_pc",    pc_out, 64'd0);
      chk("rst_instr", 64'(instr_out), 64'd0);

      // BOOT issues nothing, first request in the following cycle
      rst_n_in = 1'b1;
      #1;
      chk("boot_req", 64'(imem_req_out), 64'd0);
      tick();
      chk("run_req",   64'(imem_req_out), 64'd1);
      chk("run_addr",  imem_addr_out, 64'd0);
      chk("run_valid", 64'(instr_valid_out), 64'd0);
      tick();
      chk("fill_valid", 64'(instr_valid_out), 64'd0);
      chk("fill_addr",  imem_addr_out, 64'd4);
      tick();
      chk("first_valid", 64'(instr_valid_out), 64'd1);
      chk("first_pc",    pc_out, 64'd0);
      chk("first_instr", 64'(instr_out), 64'd0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("stream_pc",    pc_out, 64'(4 * i));
         chk("stream_instr", 64'(instr_out), 64'(i));
      end

      // Stall: occupancy saturates, requests stop
      instr_ready_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i >= 1) chk("stall_req", 64'(imem_req_out), 64'd0);
      end
      chk("stall_count", 64'(count_out), 64'd4);
      chk("stall_pc",    pc_out, 64'd12);

      // Resume: nothing lost
      instr_ready_in = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("resume_pc", pc_out, 64'(12 + 4 * i));
      end

      // Branch redirect with a response in flight
      tick();
      br_redirect_in = 1'b1; br_pc_in = 64'h100;
      #1;
      chk("br_req",  64'(imem_req_out), 64'd1);
      chk("br_addr", imem_addr_out, 64'h100);
      chk("br_head", pc_out, 64'd36);
      tick();
      br_redirect_in = 1'b0;
      chk("br_flush_valid", 64'(instr_valid_out), 64'd0);
      chk("br_flush_count", 64'(count_out), 64'd0);
      chk("br_hold_pc",     pc_out, 64'd36);
      tick();
      chk("br_new_valid", 64'(instr_valid_out), 64'd1);
      chk("br_new_pc",    pc_out, 64'h100);
      chk("br_new_instr", 64'(instr_out), 64'h40);
      tick();
      chk("br_next_pc", pc_out, 64'h104);

      // Interrupt pending masks the branch, interrupt taken
      int_pending_in = 1'b1; br_redirect_in = 1'b1; br_pc_in = 64'h300;
      int_redirect_in = 1'b1; int_pc_in = 64'h200;
      #1;
      chk("int_addr", imem_addr_out, 64'h200);
      tick();
      int_pending_in = 1'b0; br_redirect_in = 1'b0; int_redirect_in = 1'b0;
      chk("int_flush_valid", 64'(instr_valid_out), 64'd0);
      tick();
      chk("int_pc",    pc_out, 64'h200);
      chk("int_instr", 64'(instr_out), 64'h80);

      // Branch alone is ignored while interrupt pending
      tick();
      int_pending_in = 1'b1; br_redirect_in = 1'b1; br_pc_in = 64'h500;
      #1;
      chk("mask_req",  64'(imem_req_out), 64'd1);
      chk("mask_addr", imem_addr_out, 64'h20C);
      tick();
      int_pending_in = 1'b0; br_redirect_in = 1'b0;
      chk("mask_valid", 64'(instr_valid_out), 64'd1);
      chk("mask_pc",    pc_out, 64'h208);

      // Prediction then branch next cycle: FLUSH restarts, unaligned target aligned
      pred_redirect_in = 1'b1; pred_pc_in = 64'h40;
      #1;
      chk("pred_addr", imem_addr_out, 64'h40);
      tick();
      pred_redirect_in = 1'b0;
      br_redirect_in = 1'b1; br_pc_in = 64'h83;
      #1;
      chk("rebr_addr",  imem_addr_out, 64'h80);
      chk("rebr_valid", 64'(instr_valid_out), 64'd0);
      chk("rebr_hold",  pc_out, 64'h208);
      tick();
      br_redirect_in = 1'b0;
      chk("rebr_flush_valid", 64'(instr_valid_out), 64'd0);
      tick();
      chk("rebr_valid2", 64'(instr_valid_out), 64'd1);
      chk("rebr_pc",     pc_out, 64'h80);
      chk("rebr_instr",  64'(instr_out), 64'h20);

      // Fetch PC wraps modulo 2^XLEN
      br_redirect_in = 1'b1; br_pc_in = 64'hFFFF_FFFF_FFFF_FFFE;
      #1;
      chk("wrap_addr", imem_addr_out, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      br_redirect_in = 1'b0;
      #1;
      chk("wrap_next_addr", imem_addr_out, 64'd0);
      tick();
      chk("wrap_pc",    pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_instr", 64'(instr_out), 64'hFFFF_FFFF);
      tick();
      chk("wrap_pc0", pc_out, 64'd0);

      // Reset mid-stream with a full queue
      instr_ready_in = 1'b0;
      repeat (8) tick();
      chk("full_count", 64'(count_out), 64'd4);
      #1;
      rst_n_in = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(instr_valid_out), 64'd0);
      chk("mid_rst_count", 64'(count_out), 64'd0);
      chk("mid_rst_req",   64'(imem_req_out), 64'd0);
      chk("mid_rst_addr",  imem_addr_out, 64'd0);
      chk("mid_rst_pc",    pc_out, 64'd0);
      chk("mid_rst_instr", 64'(instr_out), 64'd0);
      instr_ready_in = 1'b1;
      tick();
      rst_n_in = 1'b1;
      n = 0;
      while (!instr_valid_out && n < 10) begin
         tick();
         n++;
      end
      chk("restart_latency", 64'(n), 64'd3);
      chk("restart_pc",      pc_out, 64'd0);
      tick();
      chk("restart_pc1", pc_out, 64'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
